booth4_seq_mult: RTL and testbench



---
 rtl/booth4_seq_mult_if.sv | 24 ++
 rtl/booth4_seq_mult.sv | 109 ++++++++++
 tb/tb_booth4_seq_mult.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/booth4_seq_mult_if.sv
// Operand/product handshake bundle for the sequential radix-4 Booth multiplier.
// The master side supplies the operands and drains the product.
interface booth4_seq_mult_if #(
    parameter int WIDTH = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth4_seq_mult.sv
// Iterative radix-4 modified-Booth multiplier, one digit per clock, signed or unsigned.
// Shift-left organisation: the multiplicand moves up two bits per digit while the multiplier moves down.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready = 1
// CALC  | accumulating ITER Booth digits, then one cycle to load product
// DONE  | product valid, waiting for out_ready
module booth4_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    booth4_seq_mult_if.slave bus
);
    localparam int EXT   = WIDTH + 2;
    localparam int ITER  = WIDTH / 2 + 1;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     mcand_q, mcand_d;
    logic [EXT:0]         mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [EXT-1:0]       a_ext;
    logic [EXT-1:0]       b_ext;
    logic [2:0]           digit;
    logic                 pp_one;
    logic                 pp_two;
    logic                 pp_neg;
    logic [ACC_W-1:0]     pp_mag;
    logic [ACC_W-1:0]     addend;

    assign a_ext = {{2{bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};
    assign b_ext = {{2{bus.signed_mode & bus.b[WIDTH-1]}}, bus.b};

    // Booth flags: 111 and 000 give zero, so negate is masked when both low bits are set
    assign digit  = mplr_q[2:0];
    assign pp_one = digit[1] ^ digit[0];
    assign pp_two = (digit == 3'b011) || (digit == 3'b100);
    assign pp_neg = digit[2] & ~(digit[1] & digit[0]);
    assign pp_mag = pp_two ? (mcand_q << 1) : (pp_one ? mcand_q : '0);
    assign addend = pp_neg ? ~pp_mag : pp_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = CALC;
                    cnt_d   = CNT_W'(ITER);
                    acc_d   = '0;
                    mcand_d = {{(ACC_W-EXT){a_ext[EXT-1]}}, a_ext};
                    mplr_d  = {b_ext, 1'b0};
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    product_d = acc_q[2*WIDTH-1:0];
                end else begin
                    acc_d   = acc_q + addend + ACC_W'(pp_neg);
                    mcand_d = mcand_q << 2;
                    mplr_d  = mplr_q >> 2;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = product_q;
endmodule

// File: tb/tb_booth4_seq_mult.sv
// Directed and small randomised checks of booth4_seq_mult at WIDTH 16 and WIDTH 8.
module tb_booth4_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    booth4_seq_mult_if #(.WIDTH(16)) if16 ();
    booth4_seq_mult_if #(.WIDTH(8))  if8 ();

    booth4_seq_mult #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    booth4_seq_mult #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mul16(input string tag, input logic sm, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp, input bit hold);
        int n;
        n = 0;
        while (!if16.in_ready && n < 50) begin step(); n++; end
        check({tag, "_rdy"}, 64'(if16.in_ready), 64'd1);
        if16.in_valid    = 1'b1;
        if16.a           = a;
        if16.b           = b;
        if16.signed_mode = sm;
        step();
        if16.in_valid    = 1'b0;
        if16.a           = 16'hDEAD;
        if16.b           = 16'hBEEF;
        if16.signed_mode = ~sm;
        n = 0;
        while (!if16.out_valid && n < 50) begin step(); n++; end
        check({tag, "_lat"}, 64'(n), 64'd10);
        check({tag, "_prod"}, 64'(if16.product), 64'(exp));
        if (!hold) begin
            if16.out_ready = 1'b1;
            step();
            if16.out_ready = 1'b0;
        end
    endtask

    task automatic mul8(input string tag, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
        int n;
        n = 0;
        while (!if8.in_ready && n < 50) begin step(); n++; end
        if8.in_valid    = 1'b1;
        if8.a           = a;
        if8.b           = b;
        if8.signed_mode = sm;
        step();
        if8.in_valid    = 1'b0;
        if8.a           = 8'hA5;
        if8.b           = 8'h5A;
        if8.signed_mode = ~sm;
        n = 0;
        while (!if8.out_valid && n < 50) begin step(); n++; end
        check({tag, "_lat"}, 64'(n), 64'd6);
        check({tag, "_prod"}, 64'(if8.product), 64'(exp));
        if8.out_ready = 1'b1;
        step();
        if8.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        logic [15:0] ra, rb;
        logic [7:0]  qa, qb;
        logic        rs;
        longint      x, y;
        int          seen;

        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.signed_mode = 1'b0; if16.out_ready = 1'b0;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.signed_mode  = 1'b0; if8.out_ready  = 1'b0;

        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", 64'(if16.in_ready), 64'd1);
        check("rst_out_valid", 64'(if16.out_valid), 64'd0);
        check("rst_product", 64'(if16.product), 64'd0);
        check("rst8_in_ready", 64'(if8.in_ready), 64'd1);
        rst = 1'b0;
        step();

        mul16("s_min_sq",   1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
        mul16("u_max_sq",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
        mul16("s_m1_sq",    1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0);
        mul16("s_m1_x1",    1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 1'b0);
        mul16("s_max_min",  1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b0);
        mul16("s_zero",     1'b1, 16'h0000, 16'h1234, 32'h0000_0000, 1'b0);
        mul16("u_mixed",    1'b0, 16'h1234, 16'h5678, 32'h0626_0060, 1'b0);

        // Backpressure: stall the consumer and poke in_valid while DONE
        mul16("bp", 1'b0, 16'h0003, 16'h0005, 32'h0000_000F, 1'b1);
        held = 32'h0000_000F;
        for (int i = 0; i < 5; i++) begin
            if16.in_valid = 1'b1;
            if16.a = 16'h0102;
            if16.b = 16'h0304;
            step();
            check("bp_valid", 64'(if16.out_valid), 64'd1);
            check("bp_prod", 64'(if16.product), 64'(held));
            check("bp_ready", 64'(if16.in_ready), 64'd0);
        end
        if16.in_valid  = 1'b0;
        if16.out_ready = 1'b1;
        step();
        if16.out_ready = 1'b0;
        check("bp_release_valid", 64'(if16.out_valid), 64'd0);
        check("bp_release_ready", 64'(if16.in_ready), 64'd1);
        check("bp_hold_prod", 64'(if16.product), 64'(held));
        mul16("b2b", 1'b1, 16'hFFFE, 16'h0007, 32'hFFFF_FFF2, 1'b0);

        // Reset during the fourth Booth digit discards the operation
        if16.in_valid = 1'b1;
        if16.a = 16'h00FF;
        if16.b = 16'h00FF;
        if16.signed_mode = 1'b0;
        step();
        if16.in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", 64'(if16.in_ready), 64'd1);
        check("mid_rst_valid", 64'(if16.out_valid), 64'd0);
        check("mid_rst_prod", 64'(if16.product), 64'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (if16.out_valid) seen++;
        end
        check("mid_rst_no_out", 64'(seen), 64'd0);

        mul8("w8_s_min_sq", 1'b1, 8'h80, 8'h80, 16'h4000);
        mul8("w8_u_ff_fe",  1'b0, 8'hFF, 8'hFE, 16'hFD02);
        mul8("w8_s_ff_fe",  1'b1, 8'hFF, 8'hFE, 16'h0002);
        mul8("w8_s_7f_80",  1'b1, 8'h7F, 8'h80, 16'hC080);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            x  = rs ? longint'(signed'(ra)) : longint'(ra);
            y  = rs ? longint'(signed'(rb)) : longint'(rb);
            mul16("rnd16", rs, ra, rb, 32'(x * y), 1'b0);
        end
        for (int i = 0; i < 150; i++) begin
            qa = 8'($urandom);
            qb = 8'($urandom);
            rs = 1'($urandom);
            x  = rs ? longint'(signed'(qa)) : longint'(qa);
            y  = rs ? longint'(signed'(qb)) : longint'(qb);
            mul8("rnd8", rs, qa, qb, 16'(x * y));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
